// File: rtl/wr_full_ctrl_if.sv
// Write-side FIFO pointer/flag bundle between the write client and wr_full_ctrl.
// Optional macro WR_OVERFLOW_EN adds the sticky wr_overflow flag.
interface wr_full_ctrl_if #(
  parameter int unsigned ADDR_SIZE = 4
);
  logic                 wr_inc;
  logic [ADDR_SIZE:0]   rd_q2_ptr;
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic                 wr_en;
  logic                 wr_full;
  logic                 wr_almost_full;
  logic [ADDR_SIZE:0]   wr_level;
`ifdef WR_OVERFLOW_EN
  logic                 wr_overflow;

  modport master (
    output wr_inc, rd_q2_ptr,
    input  wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_inc, rd_q2_ptr,
    output wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );
`else
  modport master (
    output wr_inc, rd_q2_ptr,
    input  wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level
  );

  modport slave (
    input  wr_inc, rd_q2_ptr,
    output wr_ptr, wr_addr, wr_en, wr_full, wr_almost_full, wr_level
  );
`endif
endinterface

// File: rtl/wr_full_ctrl.sv
// Write-domain pointer, full, level and almost-full controller for the async FIFO.
// Optional macro WR_OVERFLOW_EN adds a sticky overflow flag on the interface.
module wr_full_ctrl #(
  parameter int unsigned ADDR_SIZE = 4,
  parameter int unsigned AF_MARGIN = 2
) (
  input logic           wr_clk,
  input logic           wr_rst,
  wr_full_ctrl_if.slave bus
);
  localparam int unsigned PW    = ADDR_SIZE + 1;
  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_full_cmp;
  logic [PW-1:0] rd_bin_sync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] level_q;
  logic          push;
  logic          full_next;
  logic          af_next;
  logic          full_q;
  logic          af_q;

  assign push = bus.wr_inc & ~full_q;

  // Next pointer, full compare and pessimistic level against the synced read pointer.
  always_comb begin
    wr_bin_next  = wr_bin + PW'(push);
    wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next;
    rd_full_cmp  = {~bus.rd_q2_ptr[ADDR_SIZE:ADDR_SIZE-1], bus.rd_q2_ptr[ADDR_SIZE-2:0]};
    full_next    = (wr_gray_next == rd_full_cmp);
    rd_bin_sync  = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rd_bin_sync[i] = ^(bus.rd_q2_ptr >> i);
    end
    level_next   = wr_bin_next - rd_bin_sync;
    af_next      = (level_next >= AF_THRESH);
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      wr_bin   <= '0;
      wr_ptr_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      level_q  <= '0;
    end else begin
      wr_bin   <= wr_bin_next;
      wr_ptr_q <= wr_gray_next;
      full_q   <= full_next;
      af_q     <= af_next;
      level_q  <= level_next;
    end
  end

`ifdef WR_OVERFLOW_EN
  logic ovf_q;

  // Sticky: any write request seen while full is remembered until reset.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.wr_inc & full_q);
    end
  end

  assign bus.wr_overflow = ovf_q;
`endif

  assign bus.wr_ptr         = wr_ptr_q;
  assign bus.wr_addr        = wr_bin[ADDR_SIZE-1:0];
  assign bus.wr_en          = push;
  assign bus.wr_full        = full_q;
  assign bus.wr_almost_full = af_q;
  assign bus.wr_level       = level_q;
endmodule

// File: tb/tb_wr_full_ctrl.sv
// Scoreboard bench for wr_full_ctrl (ADDR_SIZE=4, AF_MARGIN=2); WR_OVERFLOW_EN optional.
module tb_wr_full_ctrl;
  typedef struct packed {
    logic [4:0] ptr;
    logic [3:0] addr;
    logic       en;
    logic       full;
    logic       af;
    logic [4:0] level;
    logic       ovf;
  } exp_t;

`ifdef WR_OVERFLOW_EN
  localparam bit OVF_BUILT = 1'b1;
`else
  localparam bit OVF_BUILT = 1'b0;
`endif

  logic wr_clk;
  logic wr_rst;
  logic ovf_exp;
  int   checks;
  int   errors;

  exp_t  exp_q[$];
  string name_q[$];

  wr_full_ctrl_if #(.ADDR_SIZE(4)) bus ();

  wr_full_ctrl #(.ADDR_SIZE(4), .AF_MARGIN(2)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  function automatic logic [4:0] gray(input int unsigned b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge wr_clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    logic  ovf_act;
`ifdef WR_OVERFLOW_EN
    ovf_act = bus.wr_overflow;
`else
    ovf_act = 1'b0;
`endif
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{bus.wr_ptr, bus.wr_addr, bus.wr_en, bus.wr_full,
             bus.wr_almost_full, bus.wr_level, ovf_act};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ptr=%b addr=%0d en=%b full=%b af=%b level=%0d ovf=%b, expected ptr=%b addr=%0d en=%b full=%b af=%b level=%0d ovf=%b",
                 nm, a.ptr, a.addr, a.en, a.full, a.af, a.level, a.ovf,
                 e.ptr, e.addr, e.en, e.full, e.af, e.level, e.ovf);
      end
    end
  end

  task automatic drive(input logic inc, input logic [4:0] rq);
    bus.wr_inc    = inc;
    bus.rd_q2_ptr = rq;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] p, input logic [3:0] a,
                     input logic en, input logic full, input logic af, input logic [4:0] lv);
    exp_t e;
    e = '{p, a, en, full, af, lv, ovf_exp & OVF_BUILT};
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(negedge wr_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    ovf_exp       = 1'b0;
    wr_rst        = 1'b0;
    bus.wr_inc    = 1'b1;
    bus.rd_q2_ptr = 5'd0;

    // Reset held with wr_inc=1, then first write, then reset mid-operation.
    @(posedge wr_clk);
    #1;
    chk("rst_hold_a", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 5'd0);
    chk("rst_hold_b", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    wr_rst = 1'b1;
    drive(1'b1, 5'd0);
    chk("s1_w1", 5'b00001, 4'd1, 1'b1, 1'b0, 1'b0, 5'd1);
    drive(1'b1, 5'd0);
    wr_rst = 1'b0;
    chk("rst_mid", 5'd0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 5'd0);
    wr_rst = 1'b1;

    // Fill 16 with read pointer at 0, then an extra write while full.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 5'd0);
      chk($sformatf("s2_w%0d", i), gray(i), 4'(i), (i < 16), (i == 16), (i >= 14), 5'(i));
    end
    drive(1'b1, 5'd0);
    ovf_exp = 1'b1;
    chk("s2_w17", 5'b11000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd16);
    checks++;
    if (bus.wr_full !== 1'b1 || bus.wr_level !== 5'd16 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL s2_direct: full=%b level=%0d en=%b", bus.wr_full, bus.wr_level, bus.wr_en);
    end

    // One read seen frees a slot; one write refills.
    drive(1'b0, 5'b00001);
    chk("s3_free", 5'b11000, 4'd0, 1'b0, 1'b0, 1'b1, 5'd15);
    checks++;
    if (bus.wr_full !== 1'b0) begin
      errors++;
      $display("FAIL s3_direct: full=%b", bus.wr_full);
    end
    drive(1'b1, 5'b00001);
    chk("s3_refill", gray(17), 4'd1, 1'b0, 1'b1, 1'b1, 5'd16);

    // Write together with a read-pointer advance at level 15.
    drive(1'b0, gray(2));
    chk("s5_down", gray(17), 4'd1, 1'b0, 1'b0, 1'b1, 5'd15);
    drive(1'b1, gray(3));
    chk("s5_sim", gray(18), 4'd2, 1'b1, 1'b0, 1'b1, 5'd15);
    checks++;
    if (bus.wr_level !== 5'd15) begin
      errors++;
      $display("FAIL s5_direct: level=%0d", bus.wr_level);
    end

    // Wrap: 40 writes with the read pointer trailing by 3.
    drive(1'b0, gray(3));
    wr_rst  = 1'b0;
    ovf_exp = 1'b0;
    drive(1'b0, 5'd0);
    wr_rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 5'd0);
    for (int k = 4; k <= 43; k++) begin
      drive(1'b1, gray(k - 3));
      chk($sformatf("s4_k%0d", k), gray(k), 4'(k), 1'b1, 1'b0, 1'b0, 5'd3);
    end
    checks++;
    if (bus.wr_full !== 1'b0 || bus.wr_level !== 5'd3) begin
      errors++;
      $display("FAIL s4_direct: full=%b level=%0d", bus.wr_full, bus.wr_level);
    end

    // Overflow attempt from full; sticky through a drain, cleared by reset.
    drive(1'b0, gray(40));
    wr_rst = 1'b0;
    drive(1'b0, 5'd0);
    wr_rst = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 5'd0);
    chk("s6_full", 5'b11000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd16);
    drive(1'b1, 5'd0);
    ovf_exp = 1'b1;
    chk("s6_ovf", 5'b11000, 4'd0, 1'b0, 1'b1, 1'b1, 5'd16);
    drive(1'b0, gray(4));
    chk("s6_drain", 5'b11000, 4'd0, 1'b0, 1'b0, 1'b0, 5'd12);
    wr_rst  = 1'b0;
    ovf_exp = 1'b0;
    chk("s6_rst", 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (bus.wr_ptr !== 5'd0 || bus.wr_level !== 5'd0) begin
      errors++;
      $display("FAIL s6_direct: ptr=%b level=%0d", bus.wr_ptr, bus.wr_level);
    end

    @(negedge wr_clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wr_full_ctrl.md
Name: wr_full_ctrl

Overview:
Write-domain pointer and full-flag controller for the dual-clock asynchronous FIFO. It is the write-side counterpart of the read-side empty logic. It keeps the binary and Gray write pointers and drives the memory write address. It compares its next Gray pointer against the read pointer synchronised into the write clock domain to produce a registered full flag, a fill level and an almost-full flag. Its Gray pointer output feeds the 2-flop synchroniser into the read domain.

Parameters:
ADDR_SIZE, 4, FIFO address width; depth = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
AF_MARGIN, 2, almost-full asserts when free slots <= AF_MARGIN; legal range 1..2**ADDR_SIZE-1.

Ports:
wr_clk  input  1  write-domain clock.
wr_rst  input  1  asynchronous, active-low reset.
wr_inc  input  1  write request; one entry is pushed per cycle when the FIFO is not full.
rd_q2_ptr  input  ADDR_SIZE+1  Gray read pointer, already double-synchronised into wr_clk.
wr_ptr  output  ADDR_SIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
wr_addr  output  ADDR_SIZE  memory write address, equal to wr_bin[ADDR_SIZE-1:0].
wr_en  output  1  memory write enable = wr_inc & ~wr_full (combinational).
wr_full  output  1  registered full flag.
wr_almost_full  output  1  registered almost-full flag.
wr_level  output  ADDR_SIZE+1  registered fill level (0..2**ADDR_SIZE), pessimistic.

Behaviour:
- Reset (wr_rst=0, asynchronous): wr_bin=0, wr_ptr=0, wr_full=0, wr_almost_full=0, wr_level=0.
  - Reset mid-operation clears all state immediately, regardless of wr_inc.
- Next-state logic:
  - wr_bin_next = wr_bin + (wr_inc & ~wr_full), modulo 2**(ADDR_SIZE+1), wrapping naturally.
  - wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next.
- Every wr_clk rising edge: wr_bin <= wr_bin_next; wr_ptr <= wr_gray_next.
- Full:
  - full_next = (wr_gray_next == {~rd_q2_ptr[ADDR_SIZE:ADDR_SIZE-1], rd_q2_ptr[ADDR_SIZE-2:0]}).
  - wr_full <= full_next, so it asserts on the same edge that stores the last-filling write.
- Level:
  - rd_bin_sync = Gray-to-binary of rd_q2_ptr (XOR prefix from the MSB).
  - level_next = wr_bin_next - rd_bin_sync, ADDR_SIZE+1 bits, modulo arithmetic.
  - wr_level <= level_next.
- Almost-full: wr_almost_full <= (level_next >= 2**ADDR_SIZE - AF_MARGIN).
- Flag timing: all flags update in the same cycle as the pointer.
  - Deassertion is pessimistic: a read is seen only 2 write cycles after the read-domain update, through the synchroniser.
- Write attempted while full:
  - wr_en=0; pointer and address hold; wr_full stays 1 until the synchronised read pointer advances.
- Simultaneous write accepted and rd_q2_ptr advance in the same cycle: both terms enter level_next, so the level is unchanged net and the flags follow that result.
- Wrap: the pointer MSB toggles every 2**ADDR_SIZE writes; full and level remain correct across any number of wraps.
- Invariants:
  - wr_ptr changes by at most one Gray bit per cycle.
  - wr_level never exceeds 2**ADDR_SIZE.
  - wr_full == (wr_level == 2**ADDR_SIZE).

Optional Feature:
WR_OVERFLOW_EN
- Defined:
  - Adds output port wr_overflow (1 bit, registered, reset 0).
  - It is set on the edge after any cycle with wr_inc=1 and wr_full=1, and is sticky until wr_rst.
  - The dropped write has no other effect.
- Undefined: the port and its logic are absent; overflow attempts are silently ignored.

Test Plan:
Configuration for all scenarios: ADDR_SIZE=4, AF_MARGIN=2.
1. Reset with wr_inc=1 held -> wr_ptr=0, wr_addr=0, wr_full=0, wr_level=0 throughout; release reset, then 1 write -> wr_addr=1, wr_ptr=5'b00001, wr_level=1.
2. 16 consecutive writes with rd_q2_ptr=0 -> wr_almost_full=1 after write 14; wr_full=1 and wr_level=16 after write 16; a 17th wr_inc gives wr_en=0 and wr_addr stays 0.
3. From full, drive rd_q2_ptr=Gray(1)=5'b00001 -> next edge wr_full=0, wr_level=15, wr_almost_full=1; one write -> wr_full=1 again.
4. Wrap: drive 40 writes interleaved with rd_q2_ptr tracking wr_bin-3 -> wr_ptr MSB toggles after writes 16 and 32; wr_level=3 steady; wr_full never asserts.
5. Simultaneous event: at level 15, write together with rd_q2_ptr advancing by 1 -> wr_level stays 15; wr_full=0.
6. Overflow (WR_OVERFLOW_EN defined): fill to 16, pulse wr_inc once -> wr_overflow=1 next edge and held after reads free space; wr_rst=0 clears it to 0.
